// File: rtl/bp_common_pkg.sv
// Definitions shared by the IO NoC host endpoint and the tiles that address it:
// host register offsets, uncached message types and the header flit layout.
package bp_common_pkg;

    localparam logic [19:0] host_putchar_addr_gp  = 20'h01000;
    localparam logic [19:0] host_finish_addr_gp   = 20'h02000;
    localparam logic [19:0] host_scratch_base_gp  = 20'h03000;

    typedef enum logic [3:0] {
        e_uc_rd = 4'h2,
        e_uc_wr = 4'h3
    } io_msg_type_e;

    typedef struct packed {
        logic [36:0] addr;
        logic [2:0]  size;
        logic [3:0]  msg_type;
        logic [7:0]  src_cord;
        logic [3:0]  len;
        logic [7:0]  dst_cord;
    } io_hdr_t;

    // Bytes below 2^size are live; sizes beyond 8B are treated as a full word.
    function automatic logic [63:0] size_byte_mask(input logic [2:0] size);
        logic [63:0] mask;
        case (size)
            3'd0:    mask = 64'h0000_0000_0000_00FF;
            3'd1:    mask = 64'h0000_0000_0000_FFFF;
            3'd2:    mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bp_io_host_regs.sv
// Host register block: address decode, scratch array with size-based byte merge
// on write and byte masking on read, plus the access-error flag.
module bp_io_host_regs
    import bp_common_pkg::*;
#(
    parameter int num_scratch_p = 8
)
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        exec_v_i,
    input  logic        is_wr_i,
    input  logic [16:0] word_addr_i,
    input  logic [2:0]  size_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] rdata_o,
    output logic        putchar_wr_o,
    output logic        finish_wr_o,
    output logic        err_o
);

    localparam logic [3:0] scratch_cnt_lp = 4'(num_scratch_p);

    logic [63:0] scratch_r [num_scratch_p];
    logic [2:0]  idx_s;
    logic        scratch_hit_s;
    logic        putchar_hit_s;
    logic        finish_hit_s;
    logic [63:0] byte_mask_s;

    assign idx_s         = word_addr_i[2:0];
    assign scratch_hit_s = (word_addr_i[16:3] == host_scratch_base_gp[19:6])
                         && ({1'b0, idx_s} < scratch_cnt_lp);
    assign putchar_hit_s = (word_addr_i == host_putchar_addr_gp[19:3]);
    assign finish_hit_s  = (word_addr_i == host_finish_addr_gp[19:3]);
    assign byte_mask_s   = size_byte_mask(size_i);

    assign putchar_wr_o  = is_wr_i & putchar_hit_s;
    assign finish_wr_o   = is_wr_i & finish_hit_s;
    // Putchar/finish are write-only; anything else outside the scratch window is unmapped.
    assign err_o         = ~(scratch_hit_s | putchar_wr_o | finish_wr_o);

    // Read data: masked scratch contents, zero for every other access.
    always_comb begin
        rdata_o = 64'd0;
        if (scratch_hit_s && !is_wr_i) begin
            rdata_o = scratch_r[idx_s] & byte_mask_s;
        end else begin
            rdata_o = 64'd0;
        end
    end

    // Scratch storage: byte-merge the write data into the addressed register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_scratch_p; i++) begin
                scratch_r[i] <= 64'd0;
            end
        end else if (exec_v_i && is_wr_i && scratch_hit_s) begin
            scratch_r[idx_s] <= (scratch_r[idx_s] & ~byte_mask_s) | (wdata_i & byte_mask_s);
        end
    end

endmodule

// File: rtl/bp_io_host_endpoint.sv
// Host-side IO NoC responder: accepts one uncached cmd packet at a time, executes it
// against the host register block and returns a single resp packet before the next cmd.
module bp_io_host_endpoint
    import bp_common_pkg::*;
#(
    parameter int flit_width_p  = 64,
    parameter int cord_width_p  = 8,
    parameter int len_width_p   = 4,
    parameter int num_scratch_p = 8
)
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [cord_width_p-1:0] my_cord_i,
    input  logic [flit_width_p-1:0] cmd_flit_i,
    input  logic                    cmd_v_i,
    output logic                    cmd_ready_o,
    output logic [flit_width_p-1:0] resp_flit_o,
    output logic                    resp_v_o,
    input  logic                    resp_ready_i,
    output logic [7:0]              char_o,
    output logic                    char_v_o,
    input  logic                    char_ready_i,
    output logic                    finish_o,
    output logic [7:0]              finish_code_o,
    output logic [7:0]              err_count_o
);

    typedef enum logic [2:0] {
        ST_RX_HDR  = 3'd0,
        ST_RX_DATA = 3'd1,
        ST_EXEC    = 3'd2,
        ST_TX_HDR  = 3'd3,
        ST_TX_DATA = 3'd4,
        ST_DRAIN   = 3'd5
    } state_e;

    state_e                 state_r, state_nxt_s;
    io_hdr_t                hdr_r;
    io_hdr_t                cmd_hdr_s;
    io_hdr_t                resp_hdr_s;
    logic [63:0]            wdata_r;
    logic [63:0]            rdata_r;
    logic [len_width_p-1:0] drain_cnt_r;
    logic [7:0]             err_count_r;

    logic        cmd_fire_s;
    logic        cmd_rd_ok_s;
    logic        cmd_wr_ok_s;
    logic        hdr_is_wr_s;
    logic        exec_s;
    logic [63:0] reg_rdata_s;
    logic        putchar_wr_s;
    logic        finish_wr_s;
    logic        reg_err_s;
    logic        err_inc_s;

    assign cmd_hdr_s   = cmd_flit_i;
    assign cmd_rd_ok_s = (cmd_hdr_s.msg_type == e_uc_rd) && (cmd_hdr_s.len == 4'd0);
    assign cmd_wr_ok_s = (cmd_hdr_s.msg_type == e_uc_wr) && (cmd_hdr_s.len == 4'd1);
    assign hdr_is_wr_s = (hdr_r.msg_type == e_uc_wr);
    assign exec_s      = (state_r == ST_EXEC);

    // cmd_ready is held low for the whole time reset is asserted.
    assign cmd_ready_o = ~reset_i & ((state_r == ST_RX_HDR) || (state_r == ST_RX_DATA)
                                  || (state_r == ST_DRAIN));
    assign cmd_fire_s  = cmd_v_i & cmd_ready_o;

    bp_io_host_regs #(
        .num_scratch_p (num_scratch_p)
    ) regs (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .exec_v_i     (exec_s),
        .is_wr_i      (hdr_is_wr_s),
        .word_addr_i  (hdr_r.addr[19:3]),
        .size_i       (hdr_r.size),
        .wdata_i      (wdata_r),
        .rdata_o      (reg_rdata_s),
        .putchar_wr_o (putchar_wr_s),
        .finish_wr_o  (finish_wr_s),
        .err_o        (reg_err_s)
    );

    assign err_inc_s = ((state_r == ST_RX_HDR) && cmd_fire_s && !cmd_rd_ok_s && !cmd_wr_ok_s)
                     || (exec_s && reg_err_s);

    assign char_v_o      = exec_s & putchar_wr_s;
    assign char_o        = char_v_o ? wdata_r[7:0] : 8'd0;
    assign finish_o      = exec_s & finish_wr_s;
    assign finish_code_o = finish_o ? wdata_r[7:0] : 8'd0;
    assign resp_v_o      = (state_r == ST_TX_HDR) || (state_r == ST_TX_DATA);
    assign err_count_o   = err_count_r;

    // Response header: route back to the requester, echo the command fields.
    always_comb begin
        resp_hdr_s          = hdr_r;
        resp_hdr_s.dst_cord = hdr_r.src_cord;
        resp_hdr_s.src_cord = my_cord_i;
        resp_hdr_s.len      = hdr_is_wr_s ? 4'd0 : 4'd1;
    end

    // Response flit mux; the bus idles at zero outside the transmit states.
    always_comb begin
        resp_flit_o = {flit_width_p{1'b0}};
        case (state_r)
            ST_TX_HDR:  resp_flit_o = resp_hdr_s;
            ST_TX_DATA: resp_flit_o = rdata_r;
            default:    resp_flit_o = {flit_width_p{1'b0}};
        endcase
    end

    // Next-state logic for the receive / execute / transmit sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RX_HDR: begin
                if (cmd_fire_s) begin
                    if (cmd_wr_ok_s) begin
                        state_nxt_s = ST_RX_DATA;
                    end else if (cmd_rd_ok_s) begin
                        state_nxt_s = ST_EXEC;
                    end else if (cmd_hdr_s.len != 4'd0) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_RX_HDR;
                    end
                end else begin
                    state_nxt_s = ST_RX_HDR;
                end
            end
            ST_RX_DATA: begin
                if (cmd_fire_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_RX_DATA;
                end
            end
            ST_EXEC: begin
                if (putchar_wr_s && !char_ready_i) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_TX_HDR;
                end
            end
            ST_TX_HDR: begin
                if (resp_ready_i) begin
                    state_nxt_s = hdr_is_wr_s ? ST_RX_HDR : ST_TX_DATA;
                end else begin
                    state_nxt_s = ST_TX_HDR;
                end
            end
            ST_TX_DATA: begin
                if (resp_ready_i) begin
                    state_nxt_s = ST_RX_HDR;
                end else begin
                    state_nxt_s = ST_TX_DATA;
                end
            end
            ST_DRAIN: begin
                if (cmd_fire_s && (drain_cnt_r == 4'd1)) begin
                    state_nxt_s = ST_RX_HDR;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_RX_HDR;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= ST_RX_HDR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Command capture, drain counting and read-data staging.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hdr_r       <= '{default: '0};
            wdata_r     <= 64'd0;
            rdata_r     <= 64'd0;
            drain_cnt_r <= 4'd0;
        end else begin
            if ((state_r == ST_RX_HDR) && cmd_fire_s) begin
                hdr_r       <= cmd_hdr_s;
                drain_cnt_r <= cmd_hdr_s.len;
            end else if ((state_r == ST_DRAIN) && cmd_fire_s) begin
                drain_cnt_r <= drain_cnt_r - 4'd1;
            end
            if ((state_r == ST_RX_DATA) && cmd_fire_s) begin
                wdata_r <= cmd_flit_i;
            end
            if (exec_s) begin
                rdata_r <= reg_rdata_s;
            end
        end
    end

    // Saturating error counter.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_count_r <= 8'd0;
        end else if (err_inc_s && (err_count_r != 8'hFF)) begin
            err_count_r <= err_count_r + 8'd1;
        end
    end

endmodule

// File: tb/tb_bp_io_host_endpoint.sv
// Directed self-checking bench for bp_io_host_endpoint.
module tb_bp_io_host_endpoint;

    localparam logic [7:0] MY  = 8'h05;
    localparam logic [7:0] SRC = 8'h21;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [7:0]  my_cord_i = MY;
    logic [63:0] cmd_flit_i = 64'd0;
    logic        cmd_v_i = 1'b0;
    logic        cmd_ready_o;
    logic [63:0] resp_flit_o;
    logic        resp_v_o;
    logic        resp_ready_i = 1'b0;
    logic [7:0]  char_o;
    logic        char_v_o;
    logic        char_ready_i = 1'b0;
    logic        finish_o;
    logic [7:0]  finish_code_o;
    logic [7:0]  err_count_o;

    int n_checks = 0;
    int n_fail = 0;
    int char_xfers = 0;
    int fin_pulses = 0;
    logic [7:0] fin_code_seen = 8'd0;

    always #5 clk = ~clk;

    bp_io_host_endpoint dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .my_cord_i     (my_cord_i),
        .cmd_flit_i    (cmd_flit_i),
        .cmd_v_i       (cmd_v_i),
        .cmd_ready_o   (cmd_ready_o),
        .resp_flit_o   (resp_flit_o),
        .resp_v_o      (resp_v_o),
        .resp_ready_i  (resp_ready_i),
        .char_o        (char_o),
        .char_v_o      (char_v_o),
        .char_ready_i  (char_ready_i),
        .finish_o      (finish_o),
        .finish_code_o (finish_code_o),
        .err_count_o   (err_count_o)
    );

    always @(posedge clk) begin
        if (char_v_o && char_ready_i) char_xfers <= char_xfers + 1;
        if (finish_o) begin
            fin_pulses    <= fin_pulses + 1;
            fin_code_seen <= finish_code_o;
        end
    end

    function automatic logic [63:0] mkhdr(input logic [19:0] addr, input logic [2:0] size,
                                          input logic [3:0] mt, input logic [7:0] src,
                                          input logic [3:0] len, input logic [7:0] dst);
        return {17'd0, addr, size, mt, src, len, dst};
    endfunction

    task automatic send_flit(input logic [63:0] f);
        int n;
        cmd_flit_i = f;
        cmd_v_i    = 1'b1;
        n = 0;
        while (cmd_ready_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 40) begin
            n_fail++;
            $display("FAIL send_flit_timeout: cmd_ready_o=%b required 1", cmd_ready_o);
        end
        @(negedge clk);
        cmd_v_i    = 1'b0;
        cmd_flit_i = 64'd0;
    endtask

    task automatic recv_flit(output logic [63:0] f);
        int n;
        resp_ready_i = 1'b1;
        n = 0;
        while (resp_v_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 40) begin
            n_fail++;
            $display("FAIL recv_flit_timeout: resp_v_o=%b required 1", resp_v_o);
        end
        f = resp_flit_o;
        @(negedge clk);
        resp_ready_i = 1'b0;
    endtask

    task automatic do_write(input logic [19:0] a, input logic [2:0] sz, input logic [63:0] d,
                            output logic [63:0] rsp);
        send_flit(mkhdr(a, sz, 4'h3, SRC, 4'd1, MY));
        send_flit(d);
        recv_flit(rsp);
    endtask

    task automatic do_read(input logic [19:0] a, input logic [2:0] sz,
                           output logic [63:0] h, output logic [63:0] d);
        send_flit(mkhdr(a, sz, 4'h2, SRC, 4'd0, MY));
        recv_flit(h);
        recv_flit(d);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready_o); end
        n_checks++;
        if (resp_v_o !== 1'b0 || resp_flit_o !== 64'd0) begin
            n_fail++; $display("FAIL reset_resp: v=%b flit=%h want 0/0", resp_v_o, resp_flit_o);
        end
        n_checks++;
        if (char_v_o !== 1'b0 || finish_o !== 1'b0 || err_count_o !== 8'd0) begin
            n_fail++; $display("FAIL reset_outs: char_v=%b fin=%b err=%h want 0", char_v_o, finish_o, err_count_o);
        end
        reset_i = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", cmd_ready_o); end
        @(negedge clk);
    endtask

    task automatic test_scratch_rw();
        logic [63:0] h, d;
        do_write(20'h03008, 3'd3, 64'hDEAD_BEEF_0123_4567, h);
        n_checks++;
        if (h !== mkhdr(20'h03008, 3'd3, 4'h3, MY, 4'd0, SRC)) begin
            n_fail++; $display("FAIL wr8_resp_hdr: got %h want %h", h, mkhdr(20'h03008, 3'd3, 4'h3, MY, 4'd0, SRC));
        end
        send_flit(mkhdr(20'h03008, 3'd3, 4'h2, SRC, 4'd0, MY));
        n_checks++;
        if (resp_v_o !== 1'b0 || cmd_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL rd_exec_cycle: resp_v=%b cmd_ready=%b want 0/0", resp_v_o, cmd_ready_o);
        end
        @(negedge clk);
        n_checks++;
        if (resp_v_o !== 1'b1) begin n_fail++; $display("FAIL rd_latency: resp_v=%b want 1", resp_v_o); end
        recv_flit(h);
        recv_flit(d);
        n_checks++;
        if (h !== mkhdr(20'h03008, 3'd3, 4'h2, MY, 4'd1, SRC)) begin
            n_fail++; $display("FAIL rd8_resp_hdr: got %h want %h", h, mkhdr(20'h03008, 3'd3, 4'h2, MY, 4'd1, SRC));
        end
        n_checks++;
        if (d !== 64'hDEAD_BEEF_0123_4567) begin n_fail++; $display("FAIL rd8_data: got %h want DEADBEEF01234567", d); end
        @(negedge clk);
        n_checks++;
        if (resp_v_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL after_rd_idle: resp_v=%b cmd_ready=%b want 0/1", resp_v_o, cmd_ready_o);
        end
    endtask

    task automatic test_byte_merge();
        logic [63:0] h, d;
        do_write(20'h03000, 3'd3, 64'h1111_1111_1111_1111, h);
        do_write(20'h03000, 3'd0, 64'hFFFF_FFFF_FFFF_FFAB, h);
        do_read(20'h03000, 3'd1, h, d);
        n_checks++;
        if (h !== mkhdr(20'h03000, 3'd1, 4'h2, MY, 4'd1, SRC)) begin
            n_fail++; $display("FAIL rd2_resp_hdr: got %h want %h", h, mkhdr(20'h03000, 3'd1, 4'h2, MY, 4'd1, SRC));
        end
        n_checks++;
        if (d !== 64'h0000_0000_0000_11AB) begin n_fail++; $display("FAIL rd2_masked: got %h want 00000000000011AB", d); end
        do_read(20'h03000, 3'd3, h, d);
        n_checks++;
        if (d !== 64'h1111_1111_1111_11AB) begin n_fail++; $display("FAIL merge_1b: got %h want 11111111111111AB", d); end
        do_read(20'h0300C, 3'd2, h, d);
        n_checks++;
        if (d !== 64'h0000_0000_0123_4567) begin n_fail++; $display("FAIL rd4_low_bits_ignored: got %h want 0000000001234567", d); end
    endtask

    task automatic test_putchar();
        logic [63:0] h;
        char_ready_i = 1'b0;
        char_xfers   = 0;
        send_flit(mkhdr(20'h01000, 3'd0, 4'h3, SRC, 4'd1, MY));
        send_flit(64'h0000_0000_0000_0041);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (char_v_o !== 1'b1 || char_o !== 8'h41 || cmd_ready_o !== 1'b0 || resp_v_o !== 1'b0) begin
                n_fail++;
                $display("FAIL putchar_hold[%0d]: char_v=%b char=%h cmd_ready=%b resp_v=%b want 1/41/0/0",
                         i, char_v_o, char_o, cmd_ready_o, resp_v_o);
            end
            @(negedge clk);
        end
        char_ready_i = 1'b1;
        @(negedge clk);
        char_ready_i = 1'b0;
        recv_flit(h);
        n_checks++;
        if (h !== mkhdr(20'h01000, 3'd0, 4'h3, MY, 4'd0, SRC)) begin
            n_fail++; $display("FAIL putchar_resp_hdr: got %h want %h", h, mkhdr(20'h01000, 3'd0, 4'h3, MY, 4'd0, SRC));
        end
        n_checks++;
        if (char_xfers != 1 || char_v_o !== 1'b0) begin
            n_fail++; $display("FAIL putchar_xfers: got %0d char_v=%b want 1/0", char_xfers, char_v_o);
        end
    endtask

    task automatic test_finish();
        logic [63:0] h, d;
        fin_pulses = 0;
        send_flit(mkhdr(20'h02000, 3'd0, 4'h3, SRC, 4'd1, MY));
        send_flit(64'h0000_0000_0000_FF07);
        n_checks++;
        if (finish_o !== 1'b1 || finish_code_o !== 8'h07) begin
            n_fail++; $display("FAIL finish_pulse: fin=%b code=%h want 1/07", finish_o, finish_code_o);
        end
        @(negedge clk);
        n_checks++;
        if (finish_o !== 1'b0) begin n_fail++; $display("FAIL finish_one_cycle: fin=%b want 0", finish_o); end
        recv_flit(h);
        n_checks++;
        if (fin_pulses != 1 || fin_code_seen !== 8'h07) begin
            n_fail++; $display("FAIL finish_count: pulses=%0d code=%h want 1/07", fin_pulses, fin_code_seen);
        end
        do_read(20'h05000, 3'd3, h, d);
        n_checks++;
        if (h !== mkhdr(20'h05000, 3'd3, 4'h2, MY, 4'd1, SRC) || d !== 64'd0) begin
            n_fail++; $display("FAIL unmapped_rd: hdr=%h data=%h want %h/0", h, d, mkhdr(20'h05000, 3'd3, 4'h2, MY, 4'd1, SRC));
        end
        n_checks++;
        if (err_count_o !== 8'd1) begin n_fail++; $display("FAIL unmapped_err: got %h want 01", err_count_o); end
        do_read(20'h01000, 3'd0, h, d);
        n_checks++;
        if (d !== 64'd0 || err_count_o !== 8'd2) begin
            n_fail++; $display("FAIL putchar_rd_err: data=%h err=%h want 0/02", d, err_count_o);
        end
    endtask

    task automatic test_drain();
        logic [63:0] h, d;
        send_flit(mkhdr(20'h03008, 3'd3, 4'h9, SRC, 4'd3, MY));
        for (int i = 0; i < 3; i++) begin
            send_flit(64'hA5A5_0000_0000_0000 + 64'(i));
            n_checks++;
            if (resp_v_o !== 1'b0) begin n_fail++; $display("FAIL drain_no_resp[%0d]: resp_v=%b want 0", i, resp_v_o); end
        end
        n_checks++;
        if (err_count_o !== 8'd3 || cmd_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL drain_err: err=%h ready=%b want 03/1", err_count_o, cmd_ready_o);
        end
        do_read(20'h03008, 3'd3, h, d);
        n_checks++;
        if (d !== 64'hDEAD_BEEF_0123_4567) begin n_fail++; $display("FAIL after_drain_rd: got %h want DEADBEEF01234567", d); end
    endtask

    task automatic test_reset_mid_packet();
        logic [63:0] h, d;
        send_flit(mkhdr(20'h03008, 3'd3, 4'h2, SRC, 4'd0, MY));
        recv_flit(h);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (resp_v_o !== 1'b1 || resp_flit_o !== 64'hDEAD_BEEF_0123_4567) begin
                n_fail++; $display("FAIL tx_data_hold[%0d]: v=%b flit=%h want 1/DEADBEEF01234567", i, resp_v_o, resp_flit_o);
            end
            @(negedge clk);
        end
        reset_i = 1'b1;
        #1;
        n_checks++;
        if (resp_v_o !== 1'b0 || cmd_ready_o !== 1'b0 || err_count_o !== 8'd0) begin
            n_fail++; $display("FAIL async_reset: v=%b ready=%b err=%h want 0/0/00", resp_v_o, cmd_ready_o, err_count_o);
        end
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        do_read(20'h03008, 3'd3, h, d);
        n_checks++;
        if (d !== 64'd0) begin n_fail++; $display("FAIL scratch_cleared: got %h want 0", d); end
    endtask

    task automatic test_err_saturate();
        logic [63:0] h, d;
        for (int i = 0; i < 254; i++) send_flit(mkhdr(20'h00000, 3'd0, 4'h0, SRC, 4'd0, MY));
        n_checks++;
        if (err_count_o !== 8'hFE) begin n_fail++; $display("FAIL err_fe: got %h want FE", err_count_o); end
        for (int i = 0; i < 3; i++) send_flit(mkhdr(20'h00000, 3'd0, 4'h0, SRC, 4'd0, MY));
        n_checks++;
        if (err_count_o !== 8'hFF) begin n_fail++; $display("FAIL err_saturate: got %h want FF", err_count_o); end
        do_read(20'h03000, 3'd3, h, d);
        n_checks++;
        if (h !== mkhdr(20'h03000, 3'd3, 4'h2, MY, 4'd1, SRC) || d !== 64'd0) begin
            n_fail++; $display("FAIL after_sat_rd: hdr=%h data=%h", h, d);
        end
    endtask

    initial begin
        test_reset();
        test_scratch_rw();
        test_byte_merge();
        test_putchar();
        test_finish();
        test_drain();
        test_reset_mid_packet();
        test_err_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
